player_physics: RTL and testbench

PLAYER_PHYSICS -- requirements
Module: player_physics

---
 rtl/player_physics_if.sv | 23 ++
 rtl/player_physics.sv | 134 +++++++++++++
 tb/tb_player_physics.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/player_physics_if.sv
// Control and status bundle between the game controller and the player physics block.
// The master drives the frame/button/collision inputs; the slave (physics) reports sprite state.
interface player_physics_if;
  logic              game_tick;
  logic              jump_btn;
  logic              start;
  logic              collide;
  logic [9:0]        pos_y;
  logic signed [7:0] vel_y;
  logic [1:0]        state;
  logic              game_over;
  logic [15:0]       frame_cnt;

  modport master (
    output game_tick, jump_btn, start, collide,
    input  pos_y, vel_y, state, game_over, frame_cnt
  );

  modport slave (
    input  game_tick, jump_btn, start, collide,
    output pos_y, vel_y, state, game_over, frame_cnt
  );
endinterface

// File: rtl/player_physics.sv
// Vertical player physics: gravity, jump impulse, ceiling clamp, floor/collision death.
// state | meaning
// IDLE  | sprite parked at spawn row, waiting for start
// PLAY  | physics updates on each game_tick, collisions kill
// DEAD  | everything frozen until start returns to IDLE
module player_physics #(
  parameter int Y_MAX    = 480,
  parameter int PLAYER_H = 16,
  parameter int Y_START  = 240,
  parameter int GRAVITY  = 1,
  parameter int JUMP_VEL = -8,
  parameter int V_MAX    = 10
) (
  input logic              clk,
  input logic              rst_n,
  player_physics_if.slave  bus
);

  localparam logic [9:0]         FLOOR     = 10'(Y_MAX - PLAYER_H);
  localparam logic [9:0]         START_POS = 10'(Y_START);
  localparam logic signed [7:0]  JUMP_V    = 8'(JUMP_VEL);
  localparam logic signed [9:0]  GRAV      = 10'(GRAVITY);
  localparam logic signed [9:0]  VMAX      = 10'(V_MAX);
  localparam logic signed [11:0] FLOOR_S   = {2'b00, FLOOR};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_e;

  state_e            state_q;
  logic [9:0]        pos_q;
  logic signed [7:0] vel_q;
  logic [15:0]       frame_cnt_q;
  logic              game_over_q;
  logic              jump_q;
  logic              pending_q;

  logic              jump_edge;
  logic              jump_now;
  logic signed [9:0] vel_grav;
  logic signed [7:0] vel_d;
  logic signed [11:0] pos_d;

  // A jump edge landing on the tick itself is honoured in that same tick.
  always_comb begin
    jump_edge = bus.jump_btn & ~jump_q;
    jump_now  = pending_q | jump_edge;
    vel_grav  = {{2{vel_q[7]}}, vel_q} + GRAV;
    vel_d     = vel_q;
    if (jump_now)
      vel_d = JUMP_V;
    else if (vel_grav > VMAX)
      vel_d = VMAX[7:0];
    else
      vel_d = vel_grav[7:0];
    pos_d = {2'b00, pos_q} + {{4{vel_d[7]}}, vel_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= START_POS;
      vel_q       <= '0;
      frame_cnt_q <= '0;
      game_over_q <= 1'b0;
      jump_q      <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      jump_q      <= bus.jump_btn;
      game_over_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pos_q     <= START_POS;
          vel_q     <= '0;
          pending_q <= 1'b0;
          if (bus.start) begin
            state_q     <= PLAY;
            frame_cnt_q <= '0;
          end
        end
        PLAY: begin
          if (bus.collide) begin
            state_q     <= DEAD;
            game_over_q <= 1'b1;
            pending_q   <= 1'b0;
          end else if (bus.game_tick) begin
            pending_q <= 1'b0;
            if (pos_d >= FLOOR_S) begin
              pos_q       <= FLOOR;
              vel_q       <= '0;
              state_q     <= DEAD;
              game_over_q <= 1'b1;
            end else begin
              if (pos_d < 12'sd0) begin
                pos_q <= '0;
                vel_q <= '0;
              end else begin
                pos_q <= pos_d[9:0];
                vel_q <= vel_d;
              end
              if (frame_cnt_q != 16'hFFFF)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
          end else if (jump_edge) begin
            pending_q <= 1'b1;
          end
        end
        DEAD: begin
          pending_q <= 1'b0;
          if (bus.start) begin
            state_q <= IDLE;
            pos_q   <= START_POS;
            vel_q   <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pos_q     <= START_POS;
          vel_q     <= '0;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pos_y     = pos_q;
  assign bus.vel_y     = vel_q;
  assign bus.state     = state_q;
  assign bus.game_over = game_over_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics: vector table for the main run plus floor, ceiling and reset sequences.
`timescale 1ns/1ps
module tb_player_physics;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  player_physics_if bus ();

  player_physics dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic tick;
    logic jump;
    logic start;
    logic collide;
    int   st;
    int   pos;
    int   vel;
    int   go;
    int   fc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int pos,
                           input int vel, input int go, input int fc);
    check({tag, " state"},     int'(bus.state),     st);
    check({tag, " pos_y"},     int'(bus.pos_y),     pos);
    check({tag, " vel_y"},     int'(bus.vel_y),     vel);
    check({tag, " game_over"}, int'(bus.game_over), go);
    check({tag, " frame_cnt"}, int'(bus.frame_cnt), fc);
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic t, input logic j, input logic s, input logic c);
    @(negedge clk);
    bus.game_tick = t;
    bus.jump_btn  = j;
    bus.start     = s;
    bus.collide   = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  mv, mp, mf, vmax_seen;
    bit  dead;
    n_checks = 0;
    n_fail   = 0;

    //          tick jump start coll  st  pos  vel go fc
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 240,  0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 241,  1, 0, 1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 241,  1, 0, 1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 243,  2, 0, 2};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 246,  3, 0, 3};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 246,  3, 0, 3};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 238, -8, 0, 4};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 231, -7, 0, 5};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 231, -7, 0, 5};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 223, -8, 0, 6};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 223, -8, 1, 6};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 223, -8, 0, 6};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 223, -8, 0, 6};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 240,  0, 0, 6};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 240,  0, 0, 0};

    rst_n         = 1'b0;
    bus.game_tick = 1'b0;
    bus.jump_btn  = 1'b0;
    bus.start     = 1'b0;
    bus.collide   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 240, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].tick, vecs[i].jump, vecs[i].start, vecs[i].collide);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pos, vecs[i].vel,
                vecs[i].go, vecs[i].fc);
    end

    // Free fall from spawn to the floor, velocity capped at terminal speed.
    mv = 0; mp = 240; mf = 0; dead = 1'b0; vmax_seen = 0;
    for (int i = 0; i < 100 && !dead; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      mv = (mv + 1 > 10) ? 10 : mv + 1;
      mp = mp + mv;
      if (int'(bus.vel_y) > vmax_seen) vmax_seen = int'(bus.vel_y);
      if (mp >= 464) begin
        dead = 1'b1;
        check_all($sformatf("fall%0d", i), 2, 464, 0, 1, mf);
      end else begin
        mf++;
        check_all($sformatf("fall%0d", i), 1, mp, mv, 0, mf);
      end
    end
    check("fall reached floor", int'(dead), 1);
    check("fall terminal vel", vmax_seen, 10);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_all("floor after", 2, 464, 0, 0, 26);

    // Climb to the ceiling with repeated jumps.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("ceil start", 1, 240, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_all("ceil pre", 1, 243, 2, 0, 2);
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_all("ceil near", 1, 3, -8, 0, 32);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_all("ceil clamp", 1, 0, 0, 0, 33);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_all("ceil resume", 1, 1, 1, 0, 34);

    // Fall past row 400, then pull reset between clock edges.
    for (int i = 0; i < 60 && bus.pos_y < 10'd400; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("midrun pos reached", int'(bus.pos_y >= 10'd400), 1);
    check("midrun state", int'(bus.state), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all("async reset", 0, 240, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("restart", 1, 240, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_all("restart tick", 1, 241, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
